// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter for the 4-digit 7-segment path.
// It uses shift-and-add-3 and converts one bit per clock. Inputs above 9999
// saturate to 9999 and raise overflow.
//
// Ports:
//   clk                  rising-edge system clock
//   rst_n                synchronous reset, active-low
//   start                conversion request, sampled only while busy=0
//   bin_in               unsigned value to convert, sampled with start
//   busy                 conversion in progress (start ignored while high)
//   done                 one-cycle pulse, new digits/overflow valid this cycle
//   valid                level, bcd_data_* hold a completed result
//   overflow             last completed input was > 9999 (digits show 9999)
//   bcd_data_0..3        ones, tens, hundreds, thousands digits
module bin2bcd_seq #(
    parameter int unsigned BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic                 overflow,
    output logic [3:0]           bcd_data_0,
    output logic [3:0]           bcd_data_1,
    output logic [3:0]           bcd_data_2,
    output logic [3:0]           bcd_data_3
);

    localparam int unsigned SH_W       = 14;
    localparam int unsigned BCD_W      = 16;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned NUM_SHIFTS = 14;
    localparam int unsigned MAX_VAL    = 9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [SH_W-1:0]  shreg;
    logic [BCD_W-1:0] scratch;
    logic [CNT_W-1:0] count;
    logic             ovf_pend;

    logic [SH_W-1:0]  bin_ext;
    logic             in_ovf;
    logic [BCD_W-1:0] scratch_adj;

    // Narrower inputs are zero-extended, so the shift count never depends on BIN_WIDTH.
    assign bin_ext = SH_W'(bin_in);
    assign in_ovf  = (bin_ext > SH_W'(MAX_VAL));

    // Add 3 to every nibble >= 5 before the shift, so each digit stays 0..9.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            scratch    <= '0;
            count      <= '0;
            ovf_pend   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            bcd_data_0 <= 4'd0;
            bcd_data_1 <= 4'd0;
            bcd_data_2 <= 4'd0;
            bcd_data_3 <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg    <= in_ovf ? SH_W'(MAX_VAL) : bin_ext;
                        ovf_pend <= in_ovf;
                        scratch  <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= {scratch_adj[BCD_W-2:0], shreg[SH_W-1]};
                    shreg   <= {shreg[SH_W-2:0], 1'b0};
                    // Saturated input cannot carry out of the top digit.
                    // If it ever did, report it as overflow rather than dropping it.
                    ovf_pend <= ovf_pend | scratch_adj[BCD_W-1];
                    count    <= count + CNT_W'(1);
                    if (count == CNT_W'(NUM_SHIFTS - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_data_0 <= scratch[3:0];
                    bcd_data_1 <= scratch[7:4];
                    bcd_data_2 <= scratch[11:8];
                    bcd_data_3 <= scratch[15:12];
                    overflow   <= ovf_pend;
                    valid      <= 1'b1;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
